alarm_core_nzone: RTL and testbench

- Parametrised anti-theft alarm controller FSM; the next generation of the two-door alarm top.
- Generalised to N sensor zones with a per-zone instant/delayed trip mode, a built-in seconds prescaler and a latched trip-zone report.
- Sits between the debouncers and time_parameters (which supply the delay values) on the input side, and siren_generator / status LED on the output side.

---
 rtl/alarm_core_nzone.sv | 199 +++++++++++++++++++
 tb/tb_alarm_core_nzone.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_core_nzone.sv
// alarm_core_nzone: N-zone anti-theft alarm controller.
// Seconds prescaler, countdown timer and latched trip-zone report.
module alarm_core_nzone #(
  parameter int                 N_ZONES      = 2,
  parameter int                 TW           = 4,
  parameter int                 CLK_PER_SEC  = 50000000,
  parameter logic [N_ZONES-1:0] INSTANT_MASK = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_ZONES-1:0] zone_open,
  input  logic               disarm_req,
  input  logic               reprogram,
  input  logic [TW-1:0]      t_arm_delay,
  input  logic [TW-1:0]      t_entry_delay,
  input  logic [TW-1:0]      t_alarm_on,
  output logic [1:0]         state,
  output logic               status,
  output logic               siren_enable,
  output logic [N_ZONES-1:0] trip_zone,
  output logic               sec_tick
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    DISARMED = 2'd1,
    TRIGGER  = 2'd2,
    ON       = 2'd3
  } st_t;

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(CLK_PER_SEC - 1);

  st_t          st;
  logic [PW-1:0] psc;
  logic [TW-1:0] tmr;
  logic          arm_pending;
  logic          drv_seen;
  logic          zprev;

  logic          any_open;
  logic          inst_open;
  logic          rise0;
  logic          fall0;
  logic          tmr_zero;
  logic          expired;
  logic          ld;
  logic [TW-1:0] ld_val;

  assign state     = st;
  assign sec_tick  = (psc == PSC_MAX);
  assign any_open  = |zone_open;
  assign inst_open = |(zone_open & INSTANT_MASK);
  assign rise0     = zone_open[0] & ~zprev;
  assign fall0     = ~zone_open[0] & zprev;
  assign tmr_zero  = (tmr == '0);
  assign expired   = tmr_zero & ~ld;

  // Decide whether the timer is (re)loaded this cycle and with what.
  always_comb begin
    ld     = 1'b0;
    ld_val = '0;
    if (!reset && !disarm_req) begin
      if (reprogram) begin
        ld = 1'b1;
      end else begin
        case (st)
          ARMED: begin
            if (any_open) begin
              ld     = 1'b1;
              ld_val = inst_open ? t_alarm_on : t_entry_delay;
            end
          end
          TRIGGER: begin
            if (!ignition && (inst_open || tmr_zero)) begin
              ld     = 1'b1;
              ld_val = t_alarm_on;
            end
          end
          ON: begin
            if (any_open) begin
              ld     = 1'b1;
              ld_val = t_alarm_on;
            end
          end
          DISARMED: begin
            if (!ignition &&
                ((fall0 && drv_seen) ||
                 (arm_pending && any_open))) begin
              ld     = 1'b1;
              ld_val = t_arm_delay;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Prescaler, timer, state machine and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      st           <= ARMED;
      status       <= 1'b0;
      siren_enable <= 1'b0;
      trip_zone    <= '0;
      psc          <= '0;
      tmr          <= '0;
      arm_pending  <= 1'b0;
      drv_seen     <= 1'b0;
      zprev        <= 1'b0;
    end else begin
      zprev <= zone_open[0];

      if (ld || sec_tick) psc <= '0;
      else                psc <= psc + PW'(1);

      if (ld)
        tmr <= ld_val;
      else if (sec_tick && !tmr_zero)
        tmr <= tmr - TW'(1);

      if (disarm_req) begin
        st           <= DISARMED;
        arm_pending  <= 1'b0;
        drv_seen     <= 1'b0;
        trip_zone    <= '0;
        status       <= 1'b0;
        siren_enable <= 1'b0;
      end else if (reprogram) begin
        st           <= ARMED;
        arm_pending  <= 1'b0;
        drv_seen     <= 1'b0;
        status       <= 1'b0;
        siren_enable <= 1'b0;
      end else begin
        case (st)
          ARMED: begin
            if (any_open) begin
              trip_zone <= zone_open;
              status    <= 1'b1;
              if (inst_open) begin
                st           <= ON;
                siren_enable <= 1'b1;
              end else begin
                st <= TRIGGER;
              end
            end else if (sec_tick) begin
              status <= ~status;
            end
          end
          TRIGGER: begin
            if (ignition) begin
              st     <= DISARMED;
              status <= 1'b0;
            end else begin
              trip_zone <= trip_zone | zone_open;
              status    <= 1'b1;
              if (inst_open || tmr_zero) begin
                st           <= ON;
                siren_enable <= 1'b1;
              end
            end
          end
          ON: begin
            siren_enable <= 1'b1;
            status       <= sec_tick ? ~status : 1'b1;
            if (!any_open && expired) begin
              st           <= ARMED;
              siren_enable <= 1'b0;
              status       <= 1'b0;
            end
          end
          DISARMED: begin
            status <= 1'b0;
            if (ignition) begin
              arm_pending <= 1'b0;
              drv_seen    <= 1'b0;
            end else begin
              if (rise0)
                drv_seen <= 1'b1;
              if (fall0 && drv_seen)
                arm_pending <= 1'b1;
              if (arm_pending && !any_open && expired) begin
                st          <= ARMED;
                arm_pending <= 1'b0;
                drv_seen    <= 1'b0;
                trip_zone   <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_core_nzone.sv
// tb_alarm_core_nzone: scoreboard bench for the N-zone alarm core.
// Model tracks time as absolute cycle deadlines, not counters.
module tb_alarm_core_nzone;

  localparam int N   = 3;
  localparam int TW  = 4;
  localparam int CPS = 4;
  localparam logic [N-1:0] MASK = 3'b100;

  localparam logic [1:0] S_ARM = 2'd0;
  localparam logic [1:0] S_DIS = 2'd1;
  localparam logic [1:0] S_TRG = 2'd2;
  localparam logic [1:0] S_ON  = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ign = 1'b0;
  logic          dis = 1'b0;
  logic          rep = 1'b0;
  logic [N-1:0]  zone = '0;
  logic [TW-1:0] tarm = 4'd2;
  logic [TW-1:0] tent = 4'd3;
  logic [TW-1:0] ton  = 4'd2;

  logic [1:0]    st;
  logic          status;
  logic          siren;
  logic [N-1:0]  trip;
  logic          tick;

  always #5 clk = ~clk;

  alarm_core_nzone #(
    .N_ZONES(N), .TW(TW), .CLK_PER_SEC(CPS), .INSTANT_MASK(MASK)
  ) dut (
    .clock(clk), .reset(rst), .ignition(ign), .zone_open(zone),
    .disarm_req(dis), .reprogram(rep),
    .t_arm_delay(tarm), .t_entry_delay(tent), .t_alarm_on(ton),
    .state(st), .status(status), .siren_enable(siren),
    .trip_zone(trip), .sec_tick(tick)
  );

  typedef struct packed {
    logic [1:0]   st;
    logic         status;
    logic         siren;
    logic [N-1:0] trip;
    logic         tick;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [1:0]   m_st = S_ARM;
  logic         m_status = 1'b0;
  logic [N-1:0] m_trip = '0;
  logic         m_arm = 1'b0;
  logic         m_drv = 1'b0;
  logic         m_zp = 1'b0;
  int           k = 0;
  int           epoch = 0;
  int           exp_at = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, want);
    end
  endtask

  function automatic logic tick_at(input int c);
    return ((c - epoch) % CPS) == (CPS - 1);
  endfunction

  task automatic model_step();
    logic any, inst, tk, tz, ld, rise, fall, arm0, drv0;
    int lv;
    exp_t e;
    any  = |zone;
    inst = |(zone & MASK);
    tk   = tick_at(k);
    tz   = (k >= exp_at);
    ld   = 1'b0;
    lv   = 0;
    if (rst) begin
      m_st = S_ARM; m_status = 1'b0; m_trip = '0;
      m_arm = 1'b0; m_drv = 1'b0; m_zp = 1'b0;
      k++;
      epoch = k;
      exp_at = k;
    end else begin
      rise = zone[0] && !m_zp;
      fall = !zone[0] && m_zp;
      arm0 = m_arm;
      drv0 = m_drv;
      if (dis) begin
        m_st = S_DIS; m_arm = 1'b0; m_drv = 1'b0;
        m_trip = '0; m_status = 1'b0;
      end else if (rep) begin
        m_st = S_ARM; m_arm = 1'b0; m_drv = 1'b0;
        m_status = 1'b0; ld = 1'b1; lv = 0;
      end else begin
        case (m_st)
          S_ARM: begin
            if (any) begin
              m_trip = zone;
              m_status = 1'b1;
              ld = 1'b1;
              if (inst) begin m_st = S_ON; lv = int'(ton); end
              else begin m_st = S_TRG; lv = int'(tent); end
            end else begin
              m_status = m_status ^ tk;
            end
          end
          S_TRG: begin
            if (ign) begin
              m_st = S_DIS;
              m_status = 1'b0;
            end else begin
              m_trip = m_trip | zone;
              m_status = 1'b1;
              if (inst || tz) begin
                m_st = S_ON; ld = 1'b1; lv = int'(ton);
              end
            end
          end
          S_ON: begin
            m_status = tk ? !m_status : 1'b1;
            if (any) begin
              ld = 1'b1; lv = int'(ton);
            end else if (tz) begin
              m_st = S_ARM; m_status = 1'b0;
            end
          end
          default: begin
            m_status = 1'b0;
            if (ign) begin
              m_arm = 1'b0; m_drv = 1'b0;
            end else begin
              if (rise) m_drv = 1'b1;
              if (fall && drv0) begin
                m_arm = 1'b1; ld = 1'b1; lv = int'(tarm);
              end
              if (arm0 && any) begin
                ld = 1'b1; lv = int'(tarm);
              end
              if (!ld && arm0 && tz) begin
                m_st = S_ARM; m_arm = 1'b0;
                m_drv = 1'b0; m_trip = '0;
              end
            end
          end
        endcase
      end
      m_zp = zone[0];
      k++;
      if (ld) begin
        epoch = k;
        exp_at = k + lv * CPS;
      end
    end
    e.st     = m_st;
    e.status = m_status;
    e.siren  = (m_st == S_ON);
    e.trip   = m_trip;
    e.tick   = tick_at(k);
    q.push_back(e);
  endtask

  // apply current inputs for n cycles, predicting each outcome
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clk);
    end
  endtask

  // monitor: compare each post-edge output against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",  32'(st),     32'(e.st));
        chk("status", 32'(status), 32'(e.status));
        chk("siren",  32'(siren),  32'(e.siren));
        chk("trip",   32'(trip),   32'(e.trip));
        chk("tick",   32'(tick),   32'(e.tick));
      end
    end
  end

  initial begin
    @(negedge clk);
    // reset, disarm, driver door cycle, re-arm with restart
    rst = 1'b1; run(2);
    chk("rst_state", 32'(st), 32'(S_ARM));
    rst = 1'b0;
    dis = 1'b1; run(1);
    dis = 1'b0; run(2);
    chk("dis_state", 32'(st), 32'(S_DIS));
    zone = 3'b001; run(3);
    zone = 3'b000; run(4);
    zone = 3'b010; run(2);
    zone = 3'b000; run(6);
    chk("arm_wait", 32'(st), 32'(S_DIS));
    run(8);
    chk("armed", 32'(st), 32'(S_ARM));
    // delayed zone trip, siren, recovery
    zone = 3'b010; run(1);
    chk("trg", 32'(st), 32'(S_TRG));
    chk("trg_zone", 32'(trip), 32'(3'b010));
    zone = 3'b000; run(14);
    chk("on_siren", 32'(siren), 32'd1);
    run(12);
    chk("on_to_arm", 32'(st), 32'(S_ARM));
    // instant zone held open
    zone = 3'b100; run(1);
    chk("inst_on", 32'(st), 32'(S_ON));
    chk("inst_zone", 32'(trip), 32'(3'b100));
    run(20);
    zone = 3'b000; run(5);
    chk("hold_on", 32'(st), 32'(S_ON));
    run(7);
    chk("hold_arm", 32'(st), 32'(S_ARM));
    // ignition during entry delay
    zone = 3'b010; run(1);
    zone = 3'b000; run(4);
    ign = 1'b1; run(1);
    chk("ign_dis", 32'(st), 32'(S_DIS));
    chk("ign_trip", 32'(trip), 32'(3'b010));
    ign = 1'b0;
    dis = 1'b1; run(1);
    chk("dis_clr", 32'(trip), 32'd0);
    dis = 1'b0;
    rep = 1'b1; run(1);
    rep = 1'b0;
    // priority and mid-trigger reset
    zone = 3'b100; run(1);
    zone = 3'b000;
    dis = 1'b1; rep = 1'b1; run(1);
    chk("prio_dis", 32'(st), 32'(S_DIS));
    dis = 1'b0; run(1);
    chk("reprog", 32'(st), 32'(S_ARM));
    rep = 1'b0;
    zone = 3'b010; run(2);
    zone = 3'b000;
    rst = 1'b1; run(1);
    chk("mid_rst", 32'(st), 32'(S_ARM));
    chk("mid_rst_trip", 32'(trip), 32'd0);
    rst = 1'b0;
    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      if (i % 100 == 0) begin
        tarm = 4'($urandom_range(0, 3));
        tent = 4'($urandom_range(0, 3));
        ton  = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0)
        zone = ($urandom_range(0, 1) == 0) ? 3'b000
                                          : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0) ign = ~ign;
      dis = ($urandom_range(0, 49) == 0);
      rep = ($urandom_range(0, 69) == 0);
      rst = ($urandom_range(0, 249) == 0);
      run(1);
    end
    rst = 1'b0; dis = 1'b0; rep = 1'b0;
    run(2);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
